// File: rtl/dual_port_mem_arbiter.sv
// Round-robin arbiter sharing one dual-port memory between requesters A and B.
// Grants are combinational from state and requests, so a transfer happens in the cycle it is requested.
module dual_port_mem_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  // state | meaning
  // IDLE  | no owner; next grant goes to the sole requester, or to the one not served last
  // OWN_A | A was granted last cycle; A keeps the port up to MAX_BURST grants while B waits
  // OWN_B | B was granted last cycle; mirror of OWN_A
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  state_t          state, state_nxt;
  logic            last_b, last_b_nxt;
  logic [CW-1:0]   burst_cnt, burst_cnt_nxt;
  logic            gnt_a, gnt_b;
  logic [RD_LAT-1:0] pipe_vld, pipe_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      last_b    <= last_b_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_comb begin
    gnt_a         = 1'b0;
    gnt_b         = 1'b0;
    state_nxt     = IDLE;
    last_b_nxt    = last_b;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (a_req && (!b_req || last_b)) gnt_a = 1'b1;
        else if (b_req)                  gnt_b = 1'b1;
      end
      OWN_A: begin
        if (!a_req)                             gnt_b = b_req;
        else if (burst_cnt < MAX_CNT || !b_req) gnt_a = 1'b1;
        else                                    gnt_b = 1'b1;
      end
      OWN_B: begin
        if (!b_req)                             gnt_a = a_req;
        else if (burst_cnt < MAX_CNT || !a_req) gnt_b = 1'b1;
        else                                    gnt_a = 1'b1;
      end
      default: ;
    endcase
    // No grant may escape while reset is asserted, even with requests held high.
    if (!rst_n) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end
    if (gnt_a) begin
      state_nxt     = OWN_A;
      last_b_nxt    = 1'b0;
      burst_cnt_nxt = (state == OWN_A && burst_cnt < MAX_CNT) ? burst_cnt + ONE_CNT : ONE_CNT;
    end else if (gnt_b) begin
      state_nxt     = OWN_B;
      last_b_nxt    = 1'b1;
      burst_cnt_nxt = (state == OWN_B && burst_cnt < MAX_CNT) ? burst_cnt + ONE_CNT : ONE_CNT;
    end
  end

  assign a_gnt = gnt_a;
  assign b_gnt = gnt_b;

  assign mem_wr_en   = (gnt_a & a_we) | (gnt_b & b_we);
  assign mem_rd_en   = (gnt_a & ~a_we) | (gnt_b & ~b_we);
  assign mem_wr_addr = gnt_b ? b_addr : a_addr;
  assign mem_rd_addr = gnt_b ? b_addr : a_addr;
  assign mem_din     = gnt_b ? b_wdata : a_wdata;

  // Return pipe: one {valid, id} per issued read, id=1 means B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      pipe_id  <= '0;
    end else begin
      pipe_vld[0] <= mem_rd_en;
      pipe_id[0]  <= gnt_b;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  assign a_rvalid = pipe_vld[RD_LAT-1] & ~pipe_id[RD_LAT-1];
  assign b_rvalid = pipe_vld[RD_LAT-1] &  pipe_id[RD_LAT-1];
  assign a_rdata  = mem_dout;
  assign b_rdata  = mem_dout;

endmodule
